// File: rtl/muldiv_sequencer.sv
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Multi-cycle RV32M multiply/divide sequencer. It uses a shift-add
//            multiplier and a restoring divider, then applies sign correction
//            and selects the output word.
// Options  : MULDIV_FAST_MUL_EN -- single-step combinational multiply
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_flush,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [WIDTH-1:0] i_rs2,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREP     = 3'd1,
    S_MUL_ITER = 3'd2,
    S_DIV_ITER = 3'd3,
    S_FINAL    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [WIDTH-1:0]   rs1_q, rs1_d;
  logic [WIDTH-1:0]   rs2_q, rs2_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;

  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     div_shift, div_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
`else
  logic [WIDTH:0]     mul_sum;
`endif

  // Operand conditioning, iteration steps and sign fix-up.
  always_comb begin
    a_signed  = (funct3_q != 3'd3) && (funct3_q != 3'd5) && (funct3_q != 3'd7);
    b_signed  = a_signed && (funct3_q != 3'd2);
    a_neg     = a_signed && rs1_q[WIDTH-1];
    b_neg     = b_signed && rs2_q[WIDTH-1];
    mag_a     = a_neg ? -rs1_q : rs1_q;
    mag_b     = b_neg ? -rs2_q : rs2_q;
    // The remainder stays below the divisor, so WIDTH bits hold it after each step.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mag_q};
    q_bit     = ~div_diff[WIDTH];
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
`endif
  end

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    mag_d     = mag_q;
    rem_d     = rem_q;
    result_d  = result_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;

    if (state_q != S_IDLE && i_flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start && !i_flush) begin
            funct3_d = i_funct3;
            rs1_d    = i_rs1;
            rs2_d    = i_rs2;
            state_d  = S_PREP;
          end
        end
        S_PREP: begin
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = funct3_q[2] && (rs2_q == '0);
          cnt_d     = CNT_W'(WIDTH - 1);
          rem_d     = '0;
          if (funct3_q[2]) begin
            mag_d   = mag_b;
            acc_d   = {{WIDTH{1'b0}}, mag_a};
            state_d = (rs2_q == '0) ? S_FINAL : S_DIV_ITER;
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = fast_prod;
            state_d = S_FINAL;
`else
            mag_d   = mag_a;
            acc_d   = {{WIDTH{1'b0}}, mag_b};
            state_d = S_MUL_ITER;
`endif
          end
        end
`ifndef MULDIV_FAST_MUL_EN
        S_MUL_ITER: begin
          // Multiplier sits in the low half and shifts out LSB first.
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FINAL;
        end
`endif
        S_DIV_ITER: begin
          rem_d = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FINAL;
        end
        S_FINAL: begin
          case (funct3_q)
            3'd0:             result_d = prod_fix[WIDTH-1:0];
            3'd1, 3'd2, 3'd3: result_d = prod_fix[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:       result_d = div0_q ? '1 : quo_fix;
            default:          result_d = div0_q ? rs1_q : rem_fix;
          endcase
          state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      mag_q     <= '0;
      rem_q     <= '0;
      result_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
    end
  end

  assign o_busy   = (state_q != S_IDLE);
  assign o_done   = (state_q == S_DONE);
  assign o_result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer. It uses directed vectors
//            and multi-cycle corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_sequencer;

  localparam int WIDTH    = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT  = 2;
`else
  localparam int MUL_LAT  = WIDTH + 2;
`endif
  localparam int DIV_LAT  = WIDTH + 2;
  localparam int DIV0_LAT = 2;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        flush  = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] rs1    = '0;
  logic [31:0] rs2    = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  muldiv_sequencer #(.WIDTH(WIDTH)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_flush  (flush),
    .i_funct3 (funct3),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  // Issue one op, scramble inputs after accept, count edges from accept to o_done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    funct3  = ~f;
    rs1     = ~a;
    rs2     = b + 32'd1;
    busy_ok = busy;
    res     = 'x;
    lat     = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) begin
        res = result;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res;
    int          lat;
    logic        bok;
    int          n;
    logic        seen;

    vecs[0]  = '{"mul_7_m3",        3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1]  = '{"mulh_min_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[2]  = '{"mulhu_8_8",       3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
    vecs[3]  = '{"mulhsu_m1_2",     3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT};
    vecs[4]  = '{"mulhu_max_max",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
    vecs[5]  = '{"mul_5_6",         3'd0, 32'h0000_0005, 32'h0000_0006, 32'h0000_001E, MUL_LAT};
    vecs[6]  = '{"div_m7_2",        3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT};
    vecs[7]  = '{"rem_m7_2",        3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT};
    vecs[8]  = '{"div_overflow",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT};
    vecs[9]  = '{"rem_overflow",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT};
    vecs[10] = '{"divu_by_zero",    3'd5, 32'h0000_0064, 32'h0000_0000, 32'hFFFF_FFFF, DIV0_LAT};
    vecs[11] = '{"rem_by_zero",     3'd6, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, DIV0_LAT};
    vecs[12] = '{"divu_100_7",      3'd5, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, DIV_LAT};
    vecs[13] = '{"remu_100_7",      3'd7, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, DIV_LAT};
    vecs[14] = '{"div_7_m2",        3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT};
    vecs[15] = '{"rem_7_m2",        3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT};
    vecs[16] = '{"rem_m7_by_zero",  3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, DIV0_LAT};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, res, lat, bok);
      check({vecs[i].name, "_result"},  res,           vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat,           vecs[i].lat);
      check({vecs[i].name, "_busy"},    {31'd0, bok},  32'd1);
    end

    // Start and flush together in IDLE: flush wins
    @(negedge clk);
    start = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    check("start_flush_idle_busy", {31'd0, busy}, 32'd0);

    // i_start held high (with different operands) throughout a DIV is ignored
    @(negedge clk);
    funct3 = 3'd4;
    rs1    = 32'hFFFF_FFF9;
    rs2    = 32'h0000_0002;
    start  = 1'b1;
    @(posedge clk);
    #1;
    funct3 = 3'd0;
    rs1    = 32'h0000_1234;
    rs2    = 32'h0000_0003;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
    end
    start = 1'b0;
    check("held_start_result",  result, 32'hFFFF_FFFD);
    check("held_start_latency", n,      DIV_LAT);

    // Flush a DIVU during its iterations
    @(negedge clk);
    while (busy) @(negedge clk);
    funct3 = 3'd5;
    rs1    = 32'd1000;
    rs2    = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy",   {31'd0, busy}, 32'd0);
    check("flush_result", result,        32'hFFFF_FFFD);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("flush_no_done", {31'd0, seen}, 32'd0);
    run_op(3'd0, 32'd5, 32'd6, res, lat, bok);
    check("post_flush_mul_result",  res, 32'h0000_001E);
    check("post_flush_mul_latency", lat, MUL_LAT);

    // Asynchronous reset in the middle of a DIV
    @(negedge clk);
    funct3 = 3'd4;
    rs1    = 32'h8000_0000;
    rs2    = 32'hFFFF_FFFF;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy",   {31'd0, busy}, 32'd0);
    check("async_rst_done",   {31'd0, done}, 32'd0);
    check("async_rst_result", result,        32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    check("async_rst_no_done", {31'd0, seen}, 32'd0);
    run_op(3'd7, 32'd100, 32'd7, res, lat, bok);
    check("post_rst_remu_result", res, 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
